// File: rtl/stage_ex_mdu.sv
// Iterative RV32M mul/div beside EX: shift-add multiply / restoring divide, UNROLL bits per cycle.
// Latency N+1 (N=XLEN/UNROLL), 1 for div-by-zero/overflow; stall_req_o holds the pipe, rdy=0 freezes all state.
module stage_ex_mdu #(
  parameter int XLEN       = 32,
  parameter int UNROLL     = 1,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  flush_i,
  input  logic                  valid_i,
  input  logic [2:0]            funct3_i,
  input  logic [XLEN-1:0]       reg1_i,
  input  logic [XLEN-1:0]       reg2_i,
  input  logic [REG_ADDR_W-1:0] wd_i,
  input  logic                  wreg_i,
  output logic                  stall_req_o,
  output logic                  valid_o,
  output logic [REG_ADDR_W-1:0] wd_o,
  output logic                  wreg_o,
  output logic [XLEN-1:0]       wdata_o
);

  localparam int N     = XLEN / UNROLL;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t                r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [2*XLEN-1:0]     r_acc;
  logic [XLEN-1:0]       r_opd;
  logic [2:0]            r_funct3;
  logic                  r_neg;
  logic [REG_ADDR_W-1:0] r_wd;
  logic                  r_wreg;
  logic [REG_ADDR_W-1:0] r_wd_o;
  logic                  r_wreg_o;
  logic [XLEN-1:0]       r_wdata_o;

  logic                  w_is_div, w_s1, w_s2, w_neg1, w_neg2, w_res_neg;
  logic [XLEN-1:0]       w_mag1, w_mag2;
  logic                  w_div0, w_ovf, w_special;
  logic [XLEN-1:0]       w_special_res;
  logic                  w_last;
  logic [2*XLEN-1:0]     w_acc_step;
  logic [XLEN:0]         w_rem_ext;
  logic [XLEN-1:0]       w_quo;
  logic [2*XLEN:0]       w_mtmp;
  logic [2*XLEN-1:0]     w_prod;
  logic [XLEN-1:0]       w_result;

  // Operand decode at acceptance: which sources are signed, magnitudes and result sign.
  always_comb begin
    w_is_div  = funct3_i[2];
    w_s1      = (funct3_i == 3'b001) || (funct3_i == 3'b010) ||
                (funct3_i == 3'b100) || (funct3_i == 3'b110);
    w_s2      = (funct3_i == 3'b001) || (funct3_i == 3'b100) || (funct3_i == 3'b110);
    w_neg1    = w_s1 & reg1_i[XLEN-1];
    w_neg2    = w_s2 & reg2_i[XLEN-1];
    w_mag1    = w_neg1 ? (~reg1_i + 1'b1) : reg1_i;
    w_mag2    = w_neg2 ? (~reg2_i + 1'b1) : reg2_i;
    w_res_neg = (w_is_div && funct3_i[1]) ? w_neg1 : (w_neg1 ^ w_neg2);
    w_div0    = w_is_div && (reg2_i == '0);
    w_ovf     = w_is_div && !funct3_i[0] &&
                (reg1_i == {1'b1, {(XLEN-1){1'b0}}}) && (reg2_i == {XLEN{1'b1}});
    w_special = w_div0 | w_ovf;
    if (funct3_i[1]) w_special_res = w_div0 ? reg1_i : '0;
    else             w_special_res = w_div0 ? {XLEN{1'b1}} : reg1_i;
  end

  // One cycle of UNROLL steps; acc holds {partial, multiplier} or {remainder, quotient}.
  always_comb begin
    w_acc_step = r_acc;
    w_rem_ext  = '0;
    w_quo      = '0;
    w_mtmp     = '0;
    for (int i = 0; i < UNROLL; i++) begin
      if (r_funct3[2]) begin
        w_rem_ext = {w_acc_step[2*XLEN-1:XLEN], w_acc_step[XLEN-1]};
        w_quo     = {w_acc_step[XLEN-2:0], 1'b0};
        if (w_rem_ext >= {1'b0, r_opd}) begin
          w_rem_ext = w_rem_ext - {1'b0, r_opd};
          w_quo[0]  = 1'b1;
        end
        w_acc_step = {w_rem_ext[XLEN-1:0], w_quo};
      end else begin
        w_mtmp = {1'b0, w_acc_step};
        if (w_mtmp[0]) w_mtmp[2*XLEN:XLEN] = w_mtmp[2*XLEN:XLEN] + {1'b0, r_opd};
        w_mtmp     = w_mtmp >> 1;
        w_acc_step = w_mtmp[2*XLEN-1:0];
      end
    end
  end

  always_comb begin
    w_last   = (r_cnt == CNT_W'(N - 1));
    w_prod   = r_neg ? (~w_acc_step + 1'b1) : w_acc_step;
    w_result = '0;
    case (r_funct3)
      3'b000:         w_result = w_prod[XLEN-1:0];
      3'b001, 3'b010,
      3'b011:         w_result = w_prod[2*XLEN-1:XLEN];
      3'b100, 3'b101: w_result = r_neg ? (~w_acc_step[XLEN-1:0] + 1'b1) : w_acc_step[XLEN-1:0];
      default:        w_result = r_neg ? (~w_acc_step[2*XLEN-1:XLEN] + 1'b1)
                                       : w_acc_step[2*XLEN-1:XLEN];
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    stall_req_o = 1'b0;
    valid_o     = 1'b0;
    case (r_state)
      S_IDLE: stall_req_o = rst & valid_i & !flush_i;
      S_BUSY: stall_req_o = !flush_i;
      S_DONE: valid_o     = !flush_i;
      default: ;
    endcase
    if (flush_i) begin
      w_state_nxt = S_IDLE;
    end else if (rdy) begin
      case (r_state)
        S_IDLE:  if (valid_i) w_state_nxt = w_special ? S_DONE : S_BUSY;
        S_BUSY:  if (w_last) w_state_nxt = S_DONE;
        S_DONE:  w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_opd     <= '0;
      r_funct3  <= '0;
      r_neg     <= 1'b0;
      r_wd      <= '0;
      r_wreg    <= 1'b0;
      r_wd_o    <= '0;
      r_wreg_o  <= 1'b0;
      r_wdata_o <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (flush_i) begin
        r_cnt <= '0;
        if (r_state != S_IDLE) r_wreg_o <= 1'b0;
      end else if (rdy) begin
        case (r_state)
          S_IDLE: begin
            if (valid_i) begin
              r_cnt    <= '0;
              r_acc    <= {{XLEN{1'b0}}, (w_is_div ? w_mag1 : w_mag2)};
              r_opd    <= w_is_div ? w_mag2 : w_mag1;
              r_funct3 <= funct3_i;
              r_neg    <= w_res_neg;
              r_wd     <= wd_i;
              r_wreg   <= wreg_i & (wd_i != '0);
              if (w_special) begin
                r_wd_o    <= wd_i;
                r_wreg_o  <= wreg_i & (wd_i != '0);
                r_wdata_o <= w_special_res;
              end
            end
          end
          S_BUSY: begin
            r_acc <= w_acc_step;
            if (w_last) begin
              r_cnt     <= '0;
              r_wd_o    <= r_wd;
              r_wreg_o  <= r_wreg;
              r_wdata_o <= w_result;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign wd_o    = r_wd_o;
  assign wreg_o  = r_wreg_o;
  assign wdata_o = r_wdata_o;

endmodule

// File: tb/tb_stage_ex_mdu.sv
// Bench for stage_ex_mdu (XLEN=32, UNROLL=1): directed table, random ops vs arithmetic model, flush/pause/reset sequences.
module tb_stage_ex_mdu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b1;
  logic        flush_i = 1'b0;
  logic        valid_i = 1'b0;
  logic [2:0]  funct3_i = '0;
  logic [31:0] reg1_i = '0;
  logic [31:0] reg2_i = '0;
  logic [4:0]  wd_i = '0;
  logic        wreg_i = 1'b0;
  logic        stall_req_o, valid_o, wreg_o;
  logic [4:0]  wd_o;
  logic [31:0] wdata_o;

  stage_ex_mdu #(.XLEN(32), .UNROLL(1), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush_i(flush_i), .valid_i(valid_i),
    .funct3_i(funct3_i), .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
    .stall_req_o(stall_req_o), .valid_o(valid_o), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a, b;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_mdu(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] ua, ub, p;
    int          ia, ib;
    logic        ovf;
    sa  = longint'(signed'(a));
    sb  = longint'(signed'(b));
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    ia  = int'(a);
    ib  = int'(b);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * longint'(ub)); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(ia / ib);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(ia % ib);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
    return 32 + 1;
  endfunction

  // Present one op, then count cycles (accept cycle = 0) until valid_o; rdy dropped for cycles [pa, pa+pl).
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] wd, input logic wreg, input int pa, input int pl,
                       output int lat, output int stalls, output logic got,
                       output logic [31:0] data, output logic [4:0] owd, output logic owreg);
    @(negedge clk);
    funct3_i = f3; reg1_i = a; reg2_i = b; wd_i = wd; wreg_i = wreg;
    valid_i = 1'b1; rdy = 1'b1;
    #1 stalls = int'(stall_req_o);
    @(negedge clk);
    valid_i = 1'b0;
    lat = 1;
    rdy = !(lat >= pa && lat < pa + pl);
    #1;
    while (!valid_o && lat < 200) begin
      stalls += int'(stall_req_o);
      @(negedge clk);
      lat++;
      rdy = !(lat >= pa && lat < pa + pl);
      #1;
    end
    rdy   = 1'b1;
    got   = valid_o;
    data  = wdata_o;
    owd   = wd_o;
    owreg = wreg_o;
  endtask

  int          lat, stalls;
  logic        got, owreg, saw;
  logic [31:0] data, ra, rb;
  logic [4:0]  owd, rwd;
  logic [2:0]  rf;
  logic        rwr;

  initial begin
    vt.push_back('{3'd0, 32'd7,          32'hFFFF_FFFD, 5'd1,  1'b1, 32'hFFFF_FFEB, 33});
    vt.push_back('{3'd1, 32'h8000_0000,  32'h8000_0000, 5'd2,  1'b1, 32'h4000_0000, 33});
    vt.push_back('{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd3,  1'b1, 32'hFFFF_FFFE, 33});
    vt.push_back('{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd4,  1'b1, 32'hFFFF_FFFF, 33});
    vt.push_back('{3'd4, 32'hFFFF_FFF9,  32'd2,         5'd5,  1'b1, 32'hFFFF_FFFD, 33});
    vt.push_back('{3'd6, 32'hFFFF_FFF9,  32'd2,         5'd6,  1'b1, 32'hFFFF_FFFF, 33});
    vt.push_back('{3'd5, 32'd100,        32'd7,         5'd7,  1'b1, 32'd14,        33});
    vt.push_back('{3'd7, 32'd100,        32'd7,         5'd8,  1'b1, 32'd2,         33});
    vt.push_back('{3'd4, 32'd123,        32'd0,         5'd9,  1'b1, 32'hFFFF_FFFF, 1});
    vt.push_back('{3'd6, 32'd5,          32'd0,         5'd10, 1'b1, 32'd5,         1});
    vt.push_back('{3'd5, 32'd5,          32'd0,         5'd11, 1'b1, 32'hFFFF_FFFF, 1});
    vt.push_back('{3'd7, 32'd5,          32'd0,         5'd12, 1'b1, 32'd5,         1});
    vt.push_back('{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd13, 1'b1, 32'h8000_0000, 1});
    vt.push_back('{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd14, 1'b1, 32'h0,         1});
    vt.push_back('{3'd0, 32'd6,          32'd7,         5'd0,  1'b1, 32'd42,        33});

    #3;
    chk("rst_stall", stall_req_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_wd", wd_o, 0);
    chk("rst_wreg", wreg_o, 0);
    chk("rst_wdata", wdata_o, 0);
    @(negedge clk);
    rst = 1'b1;

    foreach (vt[i]) begin
      do_op(vt[i].f3, vt[i].a, vt[i].b, vt[i].wd, vt[i].wreg, 1000, 0, lat, stalls, got, data, owd, owreg);
      chk($sformatf("vec%0d_valid", i), got, 1);
      chk($sformatf("vec%0d_data", i), data, vt[i].exp);
      chk($sformatf("vec%0d_lat", i), lat, vt[i].lat);
      chk($sformatf("vec%0d_stalls", i), stalls, vt[i].lat);
      chk($sformatf("vec%0d_wd", i), owd, vt[i].wd);
      chk($sformatf("vec%0d_wreg", i), owreg, vt[i].wreg && vt[i].wd != 0);
      @(negedge clk); #1;
      chk($sformatf("vec%0d_pulse", i), valid_o, 0);
    end

    for (int k = 0; k < 40; k++) begin
      rf  = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 9))
        0: rb = 32'h0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: begin ra = 32'($urandom_range(0, 300)) - 32'd150; rb = 32'($urandom_range(0, 20)) - 32'd10; end
        default: ;
      endcase
      rwd = 5'($urandom_range(0, 31));
      rwr = 1'($urandom_range(0, 1));
      do_op(rf, ra, rb, rwd, rwr, 1000, 0, lat, stalls, got, data, owd, owreg);
      chk($sformatf("rnd%0d_f%0d_%h_%h_data", k, rf, ra, rb), data, ref_mdu(rf, ra, rb));
      chk($sformatf("rnd%0d_lat", k), lat, ref_lat(rf, ra, rb));
      chk($sformatf("rnd%0d_wreg", k), owreg, rwr && rwd != 0);
    end

    // rdy low for 5 cycles in the middle of a MUL
    do_op(3'd0, 32'd1234, 32'd5678, 5'd3, 1'b1, 10, 5, lat, stalls, got, data, owd, owreg);
    chk("pause_lat", lat, 38);
    chk("pause_data", data, 32'd7006652);
    chk("pause_stalls", stalls, 38);

    // valid_o held (not re-pulsed) while rdy=0 in the result cycle
    @(negedge clk);
    funct3_i = 3'd4; reg1_i = 32'd9; reg2_i = 32'd0; wd_i = 5'd4; wreg_i = 1'b1; valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0; rdy = 1'b0;
    #1 chk("hold_v0", valid_o, 1);
    @(negedge clk); #1 chk("hold_v1", valid_o, 1);
    @(negedge clk); rdy = 1'b1;
    #1 chk("hold_v2", valid_o, 1);
    chk("hold_data", wdata_o, 32'hFFFF_FFFF);
    @(negedge clk); #1 chk("hold_v3", valid_o, 0);

    // flush at iteration 10 of a DIV
    @(negedge clk);
    funct3_i = 3'd4; reg1_i = 32'd1000; reg2_i = 32'd3; wd_i = 5'd5; wreg_i = 1'b1; valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    repeat (10) @(negedge clk);
    flush_i = 1'b1;
    #1 chk("flush_stall", stall_req_o, 0);
    chk("flush_valid", valid_o, 0);
    @(negedge clk);
    flush_i = 1'b0;
    #1 chk("flush_idle_stall", stall_req_o, 0);
    saw = 1'b0;
    repeat (40) begin
      @(negedge clk); #1;
      if (valid_o) saw = 1'b1;
    end
    chk("flush_no_valid", saw, 0);
    do_op(3'd5, 32'd9, 32'd3, 5'd6, 1'b1, 1000, 0, lat, stalls, got, data, owd, owreg);
    chk("post_flush_data", data, 32'd3);
    chk("post_flush_lat", lat, 33);

    // async reset in the middle of an operation
    @(negedge clk);
    funct3_i = 3'd0; reg1_i = 32'd77; reg2_i = 32'd11; wd_i = 5'd7; wreg_i = 1'b1; valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1 chk("arst_stall", stall_req_o, 0);
    chk("arst_valid", valid_o, 0);
    chk("arst_wd", wd_o, 0);
    chk("arst_wreg", wreg_o, 0);
    chk("arst_wdata", wdata_o, 0);
    @(negedge clk);
    rst = 1'b1;
    do_op(3'd3, 32'h0001_0000, 32'h0003_0000, 5'd8, 1'b1, 1000, 0, lat, stalls, got, data, owd, owreg);
    chk("post_rst_data", data, 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
